a_buf_feeder: RTL and testbench

A_BUF_FEEDER -- requirements
Module: a_buf_feeder

---
 rtl/a_buf_feeder_pkg.sv | 25 ++
 rtl/a_buf_feeder_skew.sv | 43 ++++
 rtl/a_buf_feeder.sv | 119 +++++++++++
 tb/tb_a_buf_feeder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/a_buf_feeder_pkg.sv
// Shared constants, FSM encoding and lane geometry for the A-buffer feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package a_buf_feeder_pkg;

  // Array height (number of lanes) and per-lane operand width.
  localparam int SARRAY_H          = 4;
  localparam int LANE_W            = 32;
  localparam int SARRAY_LOAD_WIDTH = SARRAY_H * LANE_W;

  // Number of A buffers and the id width needed to name one.
  localparam int A_BUF_NUM  = 2;
  localparam int A_BUF_ID_W = (A_BUF_NUM > 1) ? $clog2(A_BUF_NUM) : 1;

  // Row / drain counter sized to reach SARRAY_H-1.
  localparam int               CNT_W    = (SARRAY_H > 1) ? $clog2(SARRAY_H) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SARRAY_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } feed_state_t;

endpackage

// File: rtl/a_buf_feeder_skew.sv
// One lane of the diagonal skew: stage-0 register plus DEPTH extra stages.
// Latency: DEPTH+1 non-held cycles from in_* to out_*.
// Backpressure: hold=1 freezes every stage of the lane.
// Ports: clk/rst_n clock and async active-low reset; hold freeze;
//        in_valid/in_data captured lane element; out_valid/out_data lane output.
module a_feed_skew_line
  import a_buf_feeder_pkg::*;
#(
  parameter int DEPTH = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              in_valid,
  input  logic [LANE_W-1:0] in_data,
  output logic              out_valid,
  output logic [LANE_W-1:0] out_data
);

  // Index 0 is the stage-0 register; indices 1..DEPTH are the skew stages.
  logic [DEPTH:0]    r_vld;
  logic [LANE_W-1:0] r_dat [0:DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i <= DEPTH; i++) begin
        r_dat[i] <= '0;
      end
    end else if (!hold) begin
      r_vld[0] <= in_valid;
      r_dat[0] <= in_data;
      for (int i = 1; i <= DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign out_valid = r_vld[DEPTH];
  assign out_data  = r_dat[DEPTH];

endmodule

// File: rtl/a_buf_feeder.sv
// Streams one A buffer (SARRAY_H rows) into the array left edge with diagonal skew.
// Latency: accept -> feed_done_o = 2*SARRAY_H cycles plus one per stall cycle.
// Backpressure: sarray_stall_i freezes read issue, counters and all skew stages.
// Ports: feed_req_* request handshake (ready only in IDLE); rd_a_buf_* row read
//        strobe/id and same-cycle returned row; sarray_a_* per-lane skewed
//        valid/data; feed_done_o one-cycle pulse with the last skewed element.
module a_buf_feeder
  import a_buf_feeder_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         feed_req_valid_i,
  input  logic [A_BUF_ID_W-1:0]        feed_req_buf_id_i,
  output logic                         feed_req_ready_o,
  input  logic                         sarray_stall_i,
  output logic                         rd_a_buf_valid_o,
  output logic [A_BUF_ID_W-1:0]        rd_a_buf_id_o,
  input  logic                         rd_a_buf_ret_valid_i,
  input  logic [SARRAY_LOAD_WIDTH-1:0] rd_a_buf_ret_data_i,
  output logic [SARRAY_H-1:0]          sarray_a_valid_o,
  output logic [SARRAY_LOAD_WIDTH-1:0] sarray_a_data_o,
  output logic                         feed_done_o
);

  feed_state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [A_BUF_ID_W-1:0] r_buf_id, w_buf_id_nxt;
  logic                  w_ready;
  logic                  w_issue;
  logic                  w_done;
  logic                  w_cap_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_buf_id <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_buf_id <= w_buf_id_nxt;
    end
  end

  // r_cnt is the row index in READ and the drain-cycle index in DRAIN.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_buf_id_nxt = r_buf_id;
    w_ready      = 1'b0;
    w_issue      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (feed_req_valid_i) begin
          w_state_nxt  = ST_READ;
          w_cnt_nxt    = '0;
          w_buf_id_nxt = feed_req_buf_id_i;
        end
      end
      ST_READ: begin
        if (!sarray_stall_i) begin
          w_issue = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // The final drain cycle is when lane SARRAY_H-1 presents its last row.
        if (!sarray_stall_i) begin
          if (r_cnt == CNT_LAST) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign feed_req_ready_o = w_ready;
  assign rd_a_buf_valid_o = w_issue;
  assign rd_a_buf_id_o    = r_buf_id;
  assign feed_done_o      = w_done;

  // Return data only counts when it answers a strobe issued this cycle.
  assign w_cap_vld = w_issue & rd_a_buf_ret_valid_i;

  for (genvar j = 0; j < SARRAY_H; j++) begin : g_lane
    logic [LANE_W-1:0] w_lane_in;

    // Invalid lanes carry zero data all the way down the skew line.
    assign w_lane_in = w_cap_vld ? rd_a_buf_ret_data_i[j*LANE_W +: LANE_W] : '0;

    a_feed_skew_line #(
      .DEPTH (j)
    ) u_skew (
      .clk       (clk),
      .rst_n     (rst_n),
      .hold      (sarray_stall_i),
      .in_valid  (w_cap_vld),
      .in_data   (w_lane_in),
      .out_valid (sarray_a_valid_o[j]),
      .out_data  (sarray_a_data_o[j*LANE_W +: LANE_W])
    );
  end

endmodule

// File: tb/tb_a_buf_feeder.sv
// Self-checking bench for a_buf_feeder: directed scenarios plus random traffic.
// Latency: n/a.
// Backpressure: random sarray_stall_i exercised against the reference model.
module tb_a_buf_feeder;
  import a_buf_feeder_pkg::*;

  localparam int H  = SARRAY_H;
  localparam int LW = SARRAY_LOAD_WIDTH;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  feed_req_valid_i;
  logic [A_BUF_ID_W-1:0] feed_req_buf_id_i;
  logic                  feed_req_ready_o;
  logic                  sarray_stall_i;
  logic                  rd_a_buf_valid_o;
  logic [A_BUF_ID_W-1:0] rd_a_buf_id_o;
  logic                  rd_a_buf_ret_valid_i;
  logic [LW-1:0]         rd_a_buf_ret_data_i;
  logic [H-1:0]          sarray_a_valid_o;
  logic [LW-1:0]         sarray_a_data_o;
  logic                  feed_done_o;

  a_buf_feeder dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .feed_req_valid_i     (feed_req_valid_i),
    .feed_req_buf_id_i    (feed_req_buf_id_i),
    .feed_req_ready_o     (feed_req_ready_o),
    .sarray_stall_i       (sarray_stall_i),
    .rd_a_buf_valid_o     (rd_a_buf_valid_o),
    .rd_a_buf_id_o        (rd_a_buf_id_o),
    .rd_a_buf_ret_valid_i (rd_a_buf_ret_valid_i),
    .rd_a_buf_ret_data_i  (rd_a_buf_ret_data_i),
    .sarray_a_valid_o     (sarray_a_valid_o),
    .sarray_a_data_o      (sarray_a_data_o),
    .feed_done_o          (feed_done_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a request is a count of non-stalled cycles since accept.
  // Progress k in [0,H) issues row k; k == 2H-1 is the done cycle.
  // Lane j shows the row captured j+1 non-stalled edges ago.
  bit            m_busy = 1'b0;
  int            m_k = 0;
  int            m_id = 0;
  int            m_req_cur = 0;
  int            m_req_next = 0;
  logic [H-1:0]  hist_v [$];
  logic [LW-1:0] hist_d [$];

  // Observation logs for literal expectations of directed scenarios.
  int          t;
  int          strobe_t [$];
  logic [31:0] lane2_log [$];
  int          done_t, lane0_first, lane3_first, acc2_t;

  function automatic logic [31:0] elem(int req, int i, int j);
    return (32'(req) << 16) | 32'(32'h100 * i + j);
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic mark();
    t = 0;
    strobe_t.delete();
    lane2_log.delete();
    done_t = -1;
    lane0_first = -1;
    lane3_first = -1;
    acc2_t = -1;
  endtask

  // One clock cycle: drive inputs just after an edge, check, then advance the model.
  task automatic cyc(input logic rstn_v, input logic st, input logic rv,
                     input logic rid, input logic spur);
    logic          exp_strobe, exp_done, exp_ready;
    logic [LW-1:0] row, ed;
    logic [H-1:0]  ev;
    int            n, idx;
    rst_n             = rstn_v;
    sarray_stall_i    = st;
    feed_req_valid_i  = rv;
    feed_req_buf_id_i = rid;
    if (!rstn_v) begin
      m_busy = 1'b0;
      m_k    = 0;
      hist_v.delete();
      hist_d.delete();
    end
    exp_strobe = rstn_v && m_busy && !st && (m_k < H);
    exp_done   = rstn_v && m_busy && !st && (m_k == 2*H-1);
    exp_ready  = !m_busy;
    for (int j = 0; j < H; j++) row[j*32 +: 32] = elem(m_req_cur, m_k, j);
    rd_a_buf_ret_valid_i = exp_strobe | spur;
    rd_a_buf_ret_data_i  = exp_strobe ? row : '1;
    ev = '0;
    ed = '0;
    n  = hist_v.size();
    for (int j = 0; j < H; j++) begin
      idx = n - 1 - j;
      if (idx >= 0) begin
        ev[j]          = hist_v[idx][j];
        ed[j*32 +: 32] = hist_d[idx][j*32 +: 32];
      end
    end
    #1;
    check("ready", LW'(feed_req_ready_o), LW'(exp_ready));
    check("rd_valid", LW'(rd_a_buf_valid_o), LW'(exp_strobe));
    if (exp_strobe) check("rd_id", LW'(rd_a_buf_id_o), LW'(m_id));
    if (!rstn_v) check("rd_id_rst", LW'(rd_a_buf_id_o), '0);
    check("done", LW'(feed_done_o), LW'(exp_done));
    check("lane_valid", LW'(sarray_a_valid_o), LW'(ev));
    check("lane_data", sarray_a_data_o, ed);
    if (rd_a_buf_valid_o) strobe_t.push_back(t);
    if (sarray_a_valid_o[2]) lane2_log.push_back(sarray_a_data_o[64 +: 32]);
    if (sarray_a_valid_o[0] && lane0_first < 0) lane0_first = t;
    if (sarray_a_valid_o[3] && lane3_first < 0) lane3_first = t;
    if (feed_done_o && done_t < 0) done_t = t;
    if (feed_req_valid_i && feed_req_ready_o && t > 0 && acc2_t < 0) acc2_t = t;
    t++;
    @(posedge clk);
    if (rstn_v) begin
      if (!st) begin
        hist_v.push_back({H{exp_strobe}});
        hist_d.push_back(exp_strobe ? row : '0);
        if (hist_v.size() > H) begin
          void'(hist_v.pop_front());
          void'(hist_d.pop_front());
        end
      end
      if (m_busy) begin
        if (!st) begin
          if (m_k == 2*H-1) m_busy = 1'b0;
          else m_k++;
        end
      end else if (rv) begin
        m_busy    = 1'b1;
        m_k       = 0;
        m_id      = int'(rid);
        m_req_cur = m_req_next;
        m_req_next++;
      end
    end
    #1;
  endtask

  initial begin
    rst_n                = 1'b0;
    sarray_stall_i       = 1'b0;
    feed_req_valid_i     = 1'b0;
    feed_req_buf_id_i    = '0;
    rd_a_buf_ret_valid_i = 1'b0;
    rd_a_buf_ret_data_i  = '0;
    mark();
    @(posedge clk);
    #1;

    // Reset state.
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_ready_lit", LW'(feed_req_ready_o), LW'(1));
    check("rst_lanes_lit", sarray_a_data_o, '0);

    // Single request, id 1, no stall: strobes 1-4, lane0 from 2, lane3 from 5, done at 8.
    mark();
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (11) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("a_strobe_cnt", LW'(strobe_t.size()), LW'(4));
    if (strobe_t.size() == 4) begin
      check("a_strobe_first", LW'(strobe_t[0]), LW'(1));
      check("a_strobe_last", LW'(strobe_t[3]), LW'(4));
    end
    check("a_lane0_first", LW'(lane0_first), LW'(2));
    check("a_lane3_first", LW'(lane3_first), LW'(5));
    check("a_done_t", LW'(done_t), LW'(8));
    check("a_lane2_cnt", LW'(lane2_log.size()), LW'(4));
    if (lane2_log.size() == 4) begin
      check("a_lane2_r0", LW'(lane2_log[0]), LW'(32'h002));
      check("a_lane2_r1", LW'(lane2_log[1]), LW'(32'h102));
      check("a_lane2_r2", LW'(lane2_log[2]), LW'(32'h202));
      check("a_lane2_r3", LW'(lane2_log[3]), LW'(32'h302));
    end

    // Two stall cycles during READ push everything two cycles later.
    mark();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b_done_t", LW'(done_t), LW'(10));
    check("b_strobe_cnt", LW'(strobe_t.size()), LW'(4));
    if (strobe_t.size() == 4) check("b_strobe_2nd", LW'(strobe_t[1]), LW'(4));

    // Request held high: next accept only the cycle after feed_done_o.
    mark();
    repeat (12) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("c_done_t", LW'(done_t), LW'(8));
    check("c_acc2_t", LW'(acc2_t), LW'(9));
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset after two reads; a fresh request must issue four new reads.
    mark();
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("d_rst_ready_lit", LW'(feed_req_ready_o), LW'(1));
    check("d_rst_valid_lit", LW'(sarray_a_valid_o), '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    mark();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("d_strobe_cnt", LW'(strobe_t.size()), LW'(4));
    check("d_done_t", LW'(done_t), LW'(8));

    // Spurious return in IDLE with all-ones data is ignored.
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("e_spur_valid_lit", LW'(sarray_a_valid_o), '0);
    check("e_spur_data_lit", sarray_a_data_o, '0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
